// File: rtl/stdp_stim_pkg.sv
// Shared types and defaults for the STDP stimulus stage (spike pair generator).
package stdp_stim_pkg;

  // Default width of the tick counters and the period/width/count registers.
  localparam int DEF_CNT_W = 32;

  // Default width of the signed pre->post onset offset.
  localparam int DEF_DLY_W = 32;

  // Run-control states. DONE is a single-cycle state that carries the done pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Larger of two widths. Used to size offset+width sums so they cannot overflow.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spike_window.sv
// Combinational window test: in_window is high while off <= t < off + width.
// The sum is formed one bit wider than either operand, so it never wraps.
module spike_window
  import stdp_stim_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int DLY_W = DEF_DLY_W
) (
  input  logic [CNT_W-1:0] t,
  input  logic [DLY_W-1:0] off,
  input  logic [CNT_W-1:0] width,
  output logic             in_window
);

  localparam int SUM_W = max_int(CNT_W, DLY_W) + 1;

  logic [SUM_W-1:0] t_x;
  logic [SUM_W-1:0] lo_x;
  logic [SUM_W-1:0] hi_x;

  // Widen all operands to a common size before comparing.
  always_comb begin
    t_x       = SUM_W'(t);
    lo_x      = SUM_W'(off);
    hi_x      = SUM_W'(off) + SUM_W'(width);
    in_window = (t_x >= lo_x) && (t_x < hi_x);
  end

endmodule

// File: rtl/spike_pair_gen.sv
// Spike pair generator: emits a train of pre (tp1) / post (td4) pulse pairs with
// programmable period, signed pre->post offset, pulse width and pair count.
// All timing is in clk_0_1ps ticks. tp1/td4 are registered and line up with the
// tick counter t of the same cycle, so they are decoded from the next value of t.
module spike_pair_gen
  import stdp_stim_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int DLY_W = DEF_DLY_W
) (
  input  logic                    clk_0_1ps,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    start,
  input  logic                    stop,
  input  logic [CNT_W-1:0]        period,
  input  logic signed [DLY_W-1:0] delta,
  input  logic [CNT_W-1:0]        width,
  input  logic [CNT_W-1:0]        n_pairs,
  output logic                    tp1,
  output logic                    td4,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err,
  output logic [CNT_W-1:0]        pair_cnt
);

  localparam int SUM_W = max_int(CNT_W, DLY_W) + 1;

  // Control state and counters.
  state_e           state_q,    state_d;
  logic [CNT_W-1:0] t_q,        t_d;
  logic [CNT_W-1:0] pair_cnt_q, pair_cnt_d;

  // Configuration captured on an accepted start.
  logic [CNT_W-1:0] period_q,   period_d;
  logic [CNT_W-1:0] width_q,    width_d;
  logic [CNT_W-1:0] n_pairs_q,  n_pairs_d;
  logic [DLY_W-1:0] pre_off_q,  pre_off_d;
  logic [DLY_W-1:0] post_off_q, post_off_d;

  // Registered outputs.
  logic tp1_q,     tp1_d;
  logic td4_q,     td4_d;
  logic cfg_err_q, cfg_err_d;

  // Candidate configuration decoded from the live inputs and its accept check.
  logic             delta_neg;
  logic [DLY_W-1:0] cand_pre_off;
  logic [DLY_W-1:0] cand_post_off;
  logic [DLY_W-1:0] cand_max_off;
  logic [SUM_W-1:0] cand_need;
  logic             cfg_ok;

  // Counter helpers for the running state.
  logic             t_last;
  logic [CNT_W-1:0] pair_cnt_inc;
  logic             last_pair;

  // Window decode for the next tick value.
  logic pre_win;
  logic post_win;

  // Split the signed offset into a pre delay (post fires first) or a post delay,
  // and reject configurations whose pulses would not fit inside one period.
  always_comb begin
    delta_neg     = delta[DLY_W-1];
    cand_pre_off  = delta_neg ? DLY_W'(DLY_W'(0) - delta) : '0;
    cand_post_off = delta_neg ? '0 : delta;
    cand_max_off  = (cand_pre_off > cand_post_off) ? cand_pre_off : cand_post_off;
    cand_need     = SUM_W'(cand_max_off) + SUM_W'(width);
    cfg_ok        = (width != '0) && (SUM_W'(period) >= cand_need);
  end

  // Tick wrap detection and the saturating pair counter increment.
  always_comb begin
    t_last       = (t_q == (period_q - CNT_W'(1)));
    pair_cnt_inc = (pair_cnt_q == '1) ? pair_cnt_q : (pair_cnt_q + CNT_W'(1));
    last_pair    = (n_pairs_q != '0) && (pair_cnt_inc == n_pairs_q);
  end

  // Next-state logic: run control, tick counter, pair counter and config capture.
  always_comb begin
    state_d    = state_q;
    t_d        = t_q;
    pair_cnt_d = pair_cnt_q;
    period_d   = period_q;
    width_d    = width_q;
    n_pairs_d  = n_pairs_q;
    pre_off_d  = pre_off_q;
    post_off_d = post_off_q;
    cfg_err_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && enable && !stop) begin
          if (cfg_ok) begin
            state_d    = RUN;
            t_d        = '0;
            pair_cnt_d = '0;
            period_d   = period;
            width_d    = width;
            n_pairs_d  = n_pairs;
            pre_off_d  = cand_pre_off;
            post_off_d = cand_post_off;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end

      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (enable) begin
          if (t_last) begin
            t_d        = '0;
            pair_cnt_d = pair_cnt_inc;
            if (last_pair) begin
              state_d = DONE;
            end
          end else begin
            t_d = t_q + CNT_W'(1);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pre and post pulse windows evaluated on the tick value of the next cycle.
  spike_window #(
    .CNT_W(CNT_W),
    .DLY_W(DLY_W)
  ) u_pre_window (
    .t        (t_d),
    .off      (pre_off_d),
    .width    (width_d),
    .in_window(pre_win)
  );

  spike_window #(
    .CNT_W(CNT_W),
    .DLY_W(DLY_W)
  ) u_post_window (
    .t        (t_d),
    .off      (post_off_d),
    .width    (width_d),
    .in_window(post_win)
  );

  // Pulses only exist in RUN; a frozen counter reproduces the held pulse level.
  always_comb begin
    tp1_d = 1'b0;
    td4_d = 1'b0;
    if (state_d == RUN) begin
      tp1_d = pre_win;
      td4_d = post_win;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_0_1ps) begin
    if (reset) begin
      state_q    <= IDLE;
      t_q        <= '0;
      pair_cnt_q <= '0;
      period_q   <= '0;
      width_q    <= '0;
      n_pairs_q  <= '0;
      pre_off_q  <= '0;
      post_off_q <= '0;
      tp1_q      <= 1'b0;
      td4_q      <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      pair_cnt_q <= pair_cnt_d;
      period_q   <= period_d;
      width_q    <= width_d;
      n_pairs_q  <= n_pairs_d;
      pre_off_q  <= pre_off_d;
      post_off_q <= post_off_d;
      tp1_q      <= tp1_d;
      td4_q      <= td4_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign tp1      = tp1_q;
  assign td4      = td4_q;
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign cfg_err  = cfg_err_q;
  assign pair_cnt = pair_cnt_q;

endmodule

// File: tb/tb_spike_pair_gen.sv
// Scoreboard bench for spike_pair_gen. Stimulus pushes hand-derived expected
// output snapshots tagged with the cycle they must appear in; the monitor pops
// and compares them on the falling edge of that cycle.
module tb_spike_pair_gen;

  localparam int CNT_W = 32;
  localparam int DLY_W = 32;

  logic                    clk_0_1ps = 1'b0;
  logic                    reset     = 1'b1;
  logic                    enable    = 1'b0;
  logic                    start     = 1'b0;
  logic                    stop      = 1'b0;
  logic [CNT_W-1:0]        period    = '0;
  logic signed [DLY_W-1:0] delta     = '0;
  logic [CNT_W-1:0]        width     = '0;
  logic [CNT_W-1:0]        n_pairs   = '0;
  logic                    tp1;
  logic                    td4;
  logic                    busy;
  logic                    done;
  logic                    cfg_err;
  logic [CNT_W-1:0]        pair_cnt;

  typedef struct packed {
    logic [31:0] cyc;
    logic        tp1;
    logic        td4;
    logic        busy;
    logic        done;
    logic        cfg_err;
    logic [31:0] pair_cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  exp_t  mon_e;
  string mon_nm;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;
  int run0     = 0;

  spike_pair_gen #(
    .CNT_W(CNT_W),
    .DLY_W(DLY_W)
  ) dut (
    .clk_0_1ps(clk_0_1ps),
    .reset    (reset),
    .enable   (enable),
    .start    (start),
    .stop     (stop),
    .period   (period),
    .delta    (delta),
    .width    (width),
    .n_pairs  (n_pairs),
    .tp1      (tp1),
    .td4      (td4),
    .busy     (busy),
    .done     (done),
    .cfg_err  (cfg_err),
    .pair_cnt (pair_cnt)
  );

  initial forever #5 clk_0_1ps = ~clk_0_1ps;

  always @(posedge clk_0_1ps) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input exp_t e, input string nm);
    checks++;
    if (int'(e.cyc) != cyc || tp1 !== e.tp1 || td4 !== e.td4 || busy !== e.busy ||
        done !== e.done || cfg_err !== e.cfg_err || pair_cnt !== e.pair_cnt) begin
      failures++;
      $display("[TB] FAIL %s cyc=%0d/%0d got tp1=%b td4=%b busy=%b done=%b cfg_err=%b pair_cnt=%0d want tp1=%b td4=%b busy=%b done=%b cfg_err=%b pair_cnt=%0d",
               nm, cyc, e.cyc, tp1, td4, busy, done, cfg_err, pair_cnt,
               e.tp1, e.td4, e.busy, e.done, e.cfg_err, e.pair_cnt);
    end
  endtask

  always @(negedge clk_0_1ps) begin
    while (exp_q.size() > 0 && int'(exp_q[0].cyc) <= cyc) begin
      mon_e  = exp_q.pop_front();
      mon_nm = name_q.pop_front();
      checkOutput(mon_e, mon_nm);
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_0_1ps);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic st, input logic sp, input int per, input int dl,
                               input int wd, input int np);
    start   = st;
    stop    = sp;
    period  = 32'(per);
    delta   = 32'(dl);
    width   = 32'(wd);
    n_pairs = 32'(np);
  endtask

  task automatic expectAt(input int c, input logic e_tp1, input logic e_td4, input logic e_busy,
                          input logic e_done, input logic e_cfg_err, input int e_pc,
                          input string nm);
    exp_t e;
    e.cyc      = 32'(c);
    e.tp1      = e_tp1;
    e.td4      = e_td4;
    e.busy     = e_busy;
    e.done     = e_done;
    e.cfg_err  = e_cfg_err;
    e.pair_cnt = 32'(e_pc);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Expected RUN cycles k_lo..k_hi of an unfrozen run starting at cycle r0.
  task automatic pushRun(input int r0, input int per, input int pre, input int post,
                         input int wd, input int k_lo, input int k_hi, input string nm);
    int t;
    for (int k = k_lo; k <= k_hi; k++) begin
      t = k % per;
      expectAt(r0 + k, (t >= pre) && (t < pre + wd), (t >= post) && (t < post + wd),
               1'b1, 1'b0, 1'b0, k / per, $sformatf("%s_k%0d", nm, k));
    end
  endtask

  // Start request: drive for one cycle, return the first cycle after it.
  task automatic startRun(input int per, input int dl, input int wd, input int np,
                          output int r0);
    applyStimulus(1'b1, 1'b0, per, dl, wd, np);
    tick(1);
    start = 1'b0;
    r0    = cyc;
  endtask

  initial begin
    int t;

    // Reset state.
    tick(2);
    expectAt(cyc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, "reset");
    reset  = 1'b0;
    enable = 1'b1;
    tick(1);
    expectAt(cyc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, "idle");

    // Pair train: period 50, delta 1, width 10, 6 pairs.
    $display("[TB] pair train");
    startRun(50, 1, 10, 6, run0);
    pushRun(run0, 50, 0, 1, 10, 0, 299, "train");
    expectAt(run0 + 300, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6, "train_done");
    expectAt(run0 + 301, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6, "train_idle");
    tick(301);

    // Negative delta: post leads pre by 5.
    $display("[TB] negative delta");
    startRun(20, -5, 3, 1, run0);
    pushRun(run0, 20, 5, 0, 3, 0, 19, "neg");
    expectAt(run0 + 20, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, "neg_done");
    expectAt(run0 + 21, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, "neg_idle");
    tick(21);

    // Config rejection and the exact-fit boundary.
    $display("[TB] config reject");
    startRun(10, 0, 0, 1, run0);
    expectAt(run0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, "rej_w0");
    expectAt(run0 + 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, "rej_w0_pulse");
    tick(1);
    startRun(10, 8, 3, 1, run0);
    expectAt(run0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, "rej_fit");
    startRun(11, 8, 3, 1, run0);
    pushRun(run0, 11, 0, 8, 3, 0, 10, "fit");
    expectAt(run0 + 11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, "fit_done");
    expectAt(run0 + 12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, "fit_idle");
    tick(12);

    // Start is ignored while enable is low, for both bad and good configs.
    enable = 1'b0;
    startRun(10, 0, 0, 1, run0);
    expectAt(run0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, "dis_bad");
    startRun(10, 0, 3, 1, run0);
    expectAt(run0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, "dis_good");
    enable = 1'b1;

    // Enable freeze for 4 cycles while t=2 inside the pulse.
    $display("[TB] enable freeze");
    startRun(20, 0, 6, 1, run0);
    for (int k = 0; k <= 23; k++) begin
      t = (k <= 2) ? k : ((k <= 6) ? 2 : k - 4);
      expectAt(run0 + k, t < 6, t < 6, 1'b1, 1'b0, 1'b0, 0, $sformatf("frz_k%0d", k));
    end
    expectAt(run0 + 24, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, "frz_done");
    expectAt(run0 + 25, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, "frz_idle");
    for (int i = 0; i < 25; i++) begin
      tick(1);
      if (cyc == run0 + 2) enable = 1'b0;
      if (cyc == run0 + 6) enable = 1'b1;
    end

    // Stop at t=7 of the third pair in free-run mode.
    $display("[TB] stop mid-run");
    startRun(10, 2, 4, 0, run0);
    pushRun(run0, 10, 0, 2, 4, 0, 27, "stp");
    expectAt(run0 + 28, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, "stp_idle");
    expectAt(run0 + 29, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, "stp_idle2");
    tick(27);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    tick(1);
    applyStimulus(1'b1, 1'b1, 10, 2, 4, 0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 10, 2, 4, 0);
    expectAt(cyc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, "stop_wins");
    tick(1);

    // Reset in the middle of a free run.
    $display("[TB] reset mid-run");
    startRun(10, 2, 4, 0, run0);
    pushRun(run0, 10, 0, 2, 4, 0, 14, "rst");
    expectAt(run0 + 15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, "rst_clear");
    expectAt(run0 + 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, "rst_idle");
    tick(14);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);

    // Start during RUN and during DONE is ignored.
    $display("[TB] start while busy");
    startRun(15, 3, 2, 2, run0);
    pushRun(run0, 15, 0, 3, 2, 0, 29, "busy");
    expectAt(run0 + 30, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, "busy_done");
    expectAt(run0 + 31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, "busy_idle");
    expectAt(run0 + 32, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, "busy_norun");
    tick(4);
    applyStimulus(1'b1, 1'b0, 5, 0, 1, 1);
    tick(1);
    start = 1'b0;
    tick(25);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick(1);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain pending=%0d want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
